// File: rtl/rasterizer_pkg.sv
// Shared types and helpers for the triangle raster front end.
// Holds the scan FSM encoding and the pixel-centre fixed-point conversion.
package rasterizer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BBOX,
    CLAMP,
    SCAN
  } scan_state_t;

  // Integer pixel index to the fixed-point coordinate of that pixel's centre.
  function automatic int px_centre(input int coord, input int frac);
    return (coord << frac) | (1 << (frac - 1));
  endfunction

endpackage

// File: rtl/min_max3.sv
// Signed minimum and maximum of three values; purely combinational.
// No state, no flow control.
module min_max3 #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  output logic signed [W-1:0] min_o,
  output logic signed [W-1:0] max_o
);

  logic signed [W-1:0] ab_min;
  logic signed [W-1:0] ab_max;

  assign ab_min = (a_i < b_i) ? a_i : b_i;
  assign ab_max = (a_i > b_i) ? a_i : b_i;
  assign min_o  = (ab_min < c_i) ? ab_min : c_i;
  assign max_o  = (ab_max > c_i) ? ab_max : c_i;

endmodule

// File: rtl/tri_bbox_pixel_scanner.sv
// Accepts one triangle, forms its screen-clamped bounding box and raster-scans it.
// First pixel 3 cycles after the triangle handshake edge; pixel outputs hold while px_ready_in is low.
module tri_bbox_pixel_scanner
  import rasterizer_pkg::*;
#(
  parameter int HRES   = 320,
  parameter int VRES   = 180,
  parameter int XWIDTH = 16,
  parameter int YWIDTH = 16,
  parameter int FRAC   = 4,
  parameter int HWIDTH = $clog2(HRES),
  parameter int VWIDTH = $clog2(VRES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  tri_valid_in,
  output logic                  tri_ready_out,
  input  logic [3*XWIDTH-1:0]   x_tri_in,
  input  logic [3*YWIDTH-1:0]   y_tri_in,
  output logic                  px_valid_out,
  input  logic                  px_ready_in,
  output logic [HWIDTH-1:0]     hcount_out,
  output logic [VWIDTH-1:0]     vcount_out,
  output logic [XWIDTH-1:0]     x_out,
  output logic [YWIDTH-1:0]     y_out,
  output logic [3*XWIDTH-1:0]   x_tri_out,
  output logic [3*YWIDTH-1:0]   y_tri_out,
  output logic                  last_out,
  output logic                  tri_done_out
);

  localparam logic signed [XWIDTH-1:0] XZERO = '0;
  localparam logic signed [YWIDTH-1:0] YZERO = '0;
  localparam logic signed [XWIDTH-1:0] XLIM  = XWIDTH'(HRES - 1);
  localparam logic signed [YWIDTH-1:0] YLIM  = YWIDTH'(VRES - 1);

  scan_state_t              state_q;
  logic [3*XWIDTH-1:0]      x_tri_q;
  logic [3*YWIDTH-1:0]      y_tri_q;
  logic signed [XWIDTH-1:0] xmin_q, xmax_q;
  logic signed [YWIDTH-1:0] ymin_q, ymax_q;
  logic [HWIDTH-1:0]        hmin_q, hmax_q, hcount_q;
  logic [VWIDTH-1:0]        vmax_q, vcount_q;
  logic                     px_valid_q;
  logic                     done_q;

  logic signed [XWIDTH-1:0] xv0, xv1, xv2, xmn, xmx;
  logic signed [YWIDTH-1:0] yv0, yv1, yv2, ymn, ymx;
  logic signed [XWIDTH-1:0] cxmin_d, cxmax_d;
  logic signed [YWIDTH-1:0] cymin_d, cymax_d;
  logic                     empty_d;
  logic                     last_w;
  logic                     unused_hi;

  assign xv0 = x_tri_q[0*XWIDTH +: XWIDTH];
  assign xv1 = x_tri_q[1*XWIDTH +: XWIDTH];
  assign xv2 = x_tri_q[2*XWIDTH +: XWIDTH];
  assign yv0 = y_tri_q[0*YWIDTH +: YWIDTH];
  assign yv1 = y_tri_q[1*YWIDTH +: YWIDTH];
  assign yv2 = y_tri_q[2*YWIDTH +: YWIDTH];

  min_max3 #(.W(XWIDTH)) u_x_mm (
    .a_i(xv0), .b_i(xv1), .c_i(xv2), .min_o(xmn), .max_o(xmx)
  );

  min_max3 #(.W(YWIDTH)) u_y_mm (
    .a_i(yv0), .b_i(yv1), .c_i(yv2), .min_o(ymn), .max_o(ymx)
  );

  // A box entirely off one side clamps to an inverted range, which flags it empty.
  always_comb begin
    cxmin_d = (xmin_q < XZERO) ? XZERO : xmin_q;
    cxmax_d = (xmax_q > XLIM)  ? XLIM  : xmax_q;
    cymin_d = (ymin_q < YZERO) ? YZERO : ymin_q;
    cymax_d = (ymax_q > YLIM)  ? YLIM  : ymax_q;
    empty_d = (cxmin_d > cxmax_d) || (cymin_d > cymax_d);
  end

  assign unused_hi = ^{cxmin_d[XWIDTH-1:HWIDTH], cxmax_d[XWIDTH-1:HWIDTH],
                       cymin_d[YWIDTH-1:VWIDTH], cymax_d[YWIDTH-1:VWIDTH]};

  assign last_w = px_valid_q && (hcount_q == hmax_q) && (vcount_q == vmax_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      x_tri_q    <= '0;
      y_tri_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      hmin_q     <= '0;
      hmax_q     <= '0;
      vmax_q     <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      px_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tri_valid_in) begin
            x_tri_q <= x_tri_in;
            y_tri_q <= y_tri_in;
            state_q <= BBOX;
          end
        end
        BBOX: begin
          xmin_q  <= xmn >>> FRAC;
          xmax_q  <= xmx >>> FRAC;
          ymin_q  <= ymn >>> FRAC;
          ymax_q  <= ymx >>> FRAC;
          state_q <= CLAMP;
        end
        CLAMP: begin
          if (empty_d) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            hmin_q     <= cxmin_d[HWIDTH-1:0];
            hmax_q     <= cxmax_d[HWIDTH-1:0];
            vmax_q     <= cymax_d[VWIDTH-1:0];
            hcount_q   <= cxmin_d[HWIDTH-1:0];
            vcount_q   <= cymin_d[VWIDTH-1:0];
            px_valid_q <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (px_ready_in) begin
            if (last_w) begin
              px_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else if (hcount_q < hmax_q) begin
              hcount_q <= hcount_q + HWIDTH'(1);
            end else begin
              hcount_q <= hmin_q;
              vcount_q <= vcount_q + VWIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tri_ready_out = (state_q == IDLE);
  assign px_valid_out  = px_valid_q;
  assign hcount_out    = hcount_q;
  assign vcount_out    = vcount_q;
  assign x_out         = px_valid_q ? XWIDTH'(px_centre(int'(hcount_q), FRAC)) : '0;
  assign y_out         = px_valid_q ? YWIDTH'(px_centre(int'(vcount_q), FRAC)) : '0;
  assign x_tri_out     = x_tri_q;
  assign y_tri_out     = y_tri_q;
  assign last_out      = last_w;
  assign tri_done_out  = done_q;

endmodule

// File: tb/tb_tri_bbox_pixel_scanner.sv
// Scoreboard bench for tri_bbox_pixel_scanner: expected pixels queued per triangle, popped on each pixel handshake.
module tb_tri_bbox_pixel_scanner;

  localparam int HRES = 320;
  localparam int VRES = 180;
  localparam int XW   = 16;
  localparam int YW   = 16;
  localparam int FRAC = 4;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tri_valid = 1'b0;
  logic            tri_ready;
  logic [3*XW-1:0] x_tri_in = '0;
  logic [3*YW-1:0] y_tri_in = '0;
  logic            px_valid;
  logic            px_ready = 1'b0;
  logic [HW-1:0]   hcount;
  logic [VW-1:0]   vcount;
  logic [XW-1:0]   x_o;
  logic [YW-1:0]   y_o;
  logic [3*XW-1:0] x_tri_o;
  logic [3*YW-1:0] y_tri_o;
  logic            last_o;
  logic            done_o;

  always #5 clk = ~clk;

  tri_bbox_pixel_scanner #(
    .HRES(HRES), .VRES(VRES), .XWIDTH(XW), .YWIDTH(YW), .FRAC(FRAC), .HWIDTH(HW), .VWIDTH(VW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .tri_valid_in(tri_valid), .tri_ready_out(tri_ready),
    .x_tri_in(x_tri_in), .y_tri_in(y_tri_in), .px_valid_out(px_valid), .px_ready_in(px_ready),
    .hcount_out(hcount), .vcount_out(vcount), .x_out(x_o), .y_out(y_o),
    .x_tri_out(x_tri_o), .y_tri_out(y_tri_o), .last_out(last_o), .tri_done_out(done_o)
  );

  typedef struct {
    int h;
    int v;
    bit last;
  } px_t;

  px_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int vert(input logic [47:0] v, input int i);
    logic signed [15:0] s;
    s = v[i*16 +: 16];
    return int'(s);
  endfunction

  // Reference model: floor bounds, clamp to screen, enumerate row-major.
  task automatic build_expected(input logic [47:0] xv, input logic [47:0] yv, output int n);
    int xmn, xmx, ymn, ymx;
    xmn = vert(xv, 0); xmx = xmn;
    ymn = vert(yv, 0); ymx = ymn;
    for (int i = 1; i < 3; i++) begin
      if (vert(xv, i) < xmn) xmn = vert(xv, i);
      if (vert(xv, i) > xmx) xmx = vert(xv, i);
      if (vert(yv, i) < ymn) ymn = vert(yv, i);
      if (vert(yv, i) > ymx) ymx = vert(yv, i);
    end
    xmn = xmn >>> FRAC; xmx = xmx >>> FRAC;
    ymn = ymn >>> FRAC; ymx = ymx >>> FRAC;
    if (xmn < 0) xmn = 0;
    if (ymn < 0) ymn = 0;
    if (xmx > HRES - 1) xmx = HRES - 1;
    if (ymx > VRES - 1) ymx = VRES - 1;
    n = 0;
    if (xmn <= xmx && ymn <= ymx) begin
      for (int v = ymn; v <= ymx; v++) begin
        for (int h = xmn; h <= xmx; h++) begin
          exp_q.push_back('{h: h, v: v, last: (h == xmx && v == ymx)});
          n++;
        end
      end
    end
  endtask

  // Starts and ends on a negedge; mode 0 = always ready, 1 = ready toggling.
  task automatic run_tri(input string name, input logic [47:0] xv, input logic [47:0] yv,
                         input int mode, input int abort_at);
    int n, cyc, npx, first_cyc;
    bit stalled, seen_done;
    logic [HW-1:0] sh;
    logic [VW-1:0] sv;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic sl;
    px_t e;
    build_expected(xv, yv, n);
    check_val({name, ":tri_ready"}, tri_ready, 1);
    x_tri_in = xv; y_tri_in = yv; tri_valid = 1'b1;
    cyc = 0; npx = 0; first_cyc = -1; stalled = 0; seen_done = 0;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      tri_valid = 1'b0;
      if (stalled) begin
        check_val({name, ":hold_h"}, hcount, sh);
        check_val({name, ":hold_v"}, vcount, sv);
        check_val({name, ":hold_x"}, x_o, sx);
        check_val({name, ":hold_y"}, y_o, sy);
        check_val({name, ":hold_last"}, last_o, sl);
        check_val({name, ":hold_valid"}, px_valid, 1);
        stalled = 0;
      end
      if (done_o) begin
        seen_done = 1;
      end else if (px_valid) begin
        if (npx == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_val({name, ":rst_valid"}, px_valid, 0);
          check_val({name, ":rst_ready"}, tri_ready, 1);
          check_val({name, ":rst_h"}, hcount, 0);
          check_val({name, ":rst_v"}, vcount, 0);
          check_val({name, ":rst_x"}, x_o, 0);
          check_val({name, ":rst_y"}, y_o, 0);
          check_val({name, ":rst_xtri"}, x_tri_o, 0);
          check_val({name, ":rst_last"}, last_o, 0);
          repeat (3) begin
            @(negedge clk);
            check_val({name, ":rst_no_done"}, done_o, 0);
          end
          rst_n = 1'b1;
          exp_q.delete();
          @(negedge clk);
          check_val({name, ":post_rst_no_done"}, done_o, 0);
          check_val({name, ":post_rst_valid"}, px_valid, 0);
          return;
        end
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check_val({name, ":latency"}, cyc, 3);
          check_val({name, ":xtri"}, x_tri_o, xv);
          check_val({name, ":ytri"}, y_tri_o, yv);
        end
        px_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
        if (px_ready) begin
          npx++;
          if (exp_q.size() == 0) begin
            check_val({name, ":extra_px"}, 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val({name, ":h"}, hcount, e.h);
            check_val({name, ":v"}, vcount, e.v);
            check_val({name, ":x"}, x_o, e.h * 16 + 8);
            check_val({name, ":y"}, y_o, e.v * 16 + 8);
            check_val({name, ":last"}, last_o, e.last);
          end
        end else begin
          stalled = 1;
          sh = hcount; sv = vcount; sx = x_o; sy = y_o; sl = last_o;
        end
      end
    end
    if (!seen_done) begin
      check_val({name, ":timeout"}, 0, 1);
    end else begin
      check_val({name, ":missing_px"}, exp_q.size(), 0);
      check_val({name, ":ready_in_done"}, tri_ready, 1);
      check_val({name, ":valid_in_done"}, px_valid, 0);
      if (n == 0) check_val({name, ":empty_done_cyc"}, cyc, 3);
      if (n > 0 && mode == 0) check_val({name, ":throughput"}, cyc - first_cyc, n);
    end
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("reset:ready", tri_ready, 1);
    check_val("reset:valid", px_valid, 0);
    check_val("reset:last", last_o, 0);
    check_val("reset:done", done_o, 0);
    check_val("reset:x", x_o, 0);
    check_val("reset:y", y_o, 0);
    check_val("reset:h", hcount, 0);
    check_val("reset:xtri", x_tri_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pixel at (2,2): centre 0x28,0x28.
    run_tri("one_px", {16'sd43, 16'sd46, 16'sd40}, {16'sd46, 16'sd42, 16'sd40}, 0, -1);
    // Left-clamped 2x2 box.
    run_tri("clamp_l", {16'sd0, 16'sd24, -16'sd48}, {16'sd10, 16'sd19, 16'sd0}, 0, -1);
    // Fully off-screen right.
    run_tri("offscr", {16'sd7000, 16'sd6500, 16'sd6400}, {16'sd48, 16'sd32, 16'sd16}, 0, -1);
    // 4x2 box with stalls.
    run_tri("stall4x2", {16'sd176, 16'sd216, 16'sd160}, {16'sd328, 16'sd350, 16'sd320}, 1, -1);
    // Reset on the third pixel, then a fresh triangle.
    run_tri("abort", {16'sd176, 16'sd216, 16'sd160}, {16'sd328, 16'sd350, 16'sd320}, 0, 2);
    run_tri("after_rst", {16'sd0, 16'sd24, -16'sd48}, {16'sd10, 16'sd19, 16'sd0}, 0, -1);
    // Right/top clamp, then a second triangle issued in the done cycle.
    run_tri("clamp_r", {16'sd5100, 16'sd5280, 16'sd5056}, {16'sd0, 16'sd8, -16'sd32}, 0, -1);
    run_tri("b2b", {16'sd43, 16'sd46, 16'sd40}, {16'sd46, 16'sd42, 16'sd40}, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
